// File: rtl/weight_ram_receiver.sv
// weight_ram_receiver
//   Receiving end of the weight-transfer handshake. A transfer (weight_data_done high in IDLE)
//   is captured, written into PARA_KERNEL bank RAMs (one kernel per bank, each bank at its own
//   address) in a single cycle, and acknowledged with weight_ram_ready until the transmitter
//   drops weight_data_done. After the PE array consumes a kernel set, a refill request
//   (update_weight_ram + update_weight_ram_addr) is raised and cleared by the next completed
//   load. A shared-address read port returns all banks with one cycle of latency.
//
//   Optional feature: define WEIGHT_RX_TIMEOUT_EN to build an ACK-hold watchdog. Without it
//   ACK holds indefinitely and timeout_err is tied to 0.
//
// Ports
//   clk                     clock
//   rst                     synchronous active-high reset
//   weight_data             PARA_KERNEL kernels, kernel i at [i*KK*DW +: KK*DW]
//   write_weight_data_addr  per-bank write address, bank i at [i*AW +: AW]
//   weight_data_done        transmitter data-valid level
//   weight_ram_ready        write committed, held while weight_data_done stays high
//   update_weight_ram       refill request level
//   update_weight_ram_addr  refill address replicated on every lane
//   consume                 1-cycle pulse: PE array finished the current set
//   rd_en / rd_addr         read strobe and shared bank address
//   rd_data / rd_valid      registered read data (bank i in lane i) and its valid flag
//   load_count              completed transfers, 16-bit wrapping
//   overrun                 sticky: consume arrived while a request was pending
//   timeout_err             sticky watchdog flag
module weight_ram_receiver #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned KERNEL_SIZE_MAX = 3,
  parameter int unsigned PARA_KERNEL     = 4,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                                                            clk,
  input  logic                                                            rst,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
  input  logic [ADDR_WIDTH*PARA_KERNEL-1:0]                               write_weight_data_addr,
  input  logic                                                            weight_data_done,
  output logic                                                            weight_ram_ready,
  output logic                                                            update_weight_ram,
  output logic [ADDR_WIDTH*PARA_KERNEL-1:0]                               update_weight_ram_addr,
  input  logic                                                            consume,
  input  logic                                                            rd_en,
  input  logic [ADDR_WIDTH-1:0]                                           rd_addr,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] rd_data,
  output logic                                                            rd_valid,
  output logic [15:0]                                                     load_count,
  output logic                                                            overrun,
  output logic                                                            timeout_err
);

  localparam int unsigned KK    = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int unsigned KW    = KK * DATA_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Capture happens on the IDLE->WRITE edge, so no separate capture state is needed.
  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StAck
  } state_e;

  state_e                          state_q, state_d;
  logic [KW*PARA_KERNEL-1:0]       data_q, data_d;
  logic [ADDR_WIDTH*PARA_KERNEL-1:0] addr_q, addr_d;
  logic [15:0]                     load_count_q, load_count_d;
  logic                            loaded_q, loaded_d;
  logic                            update_q, update_d;
  logic [ADDR_WIDTH*PARA_KERNEL-1:0] update_addr_q, update_addr_d;
  logic [ADDR_WIDTH-1:0]           refill_ptr_q, refill_ptr_d;
  logic                            overrun_q, overrun_d;
  // Consume that coincided with a request clearing; the new request goes up one cycle later.
  logic                            defer_q, defer_d;
  logic                            rd_valid_q;

  logic ram_we;
  logic complete;
  logic clear_req;
  logic timeout_hit;
  logic timeout_fire;

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      load_count_q  <= '0;
      loaded_q      <= 1'b0;
      update_q      <= 1'b0;
      update_addr_q <= '0;
      refill_ptr_q  <= '0;
      overrun_q     <= 1'b0;
      defer_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      loaded_q      <= loaded_d;
      update_q      <= update_d;
      update_addr_q <= update_addr_d;
      refill_ptr_q  <= refill_ptr_d;
      overrun_q     <= overrun_d;
      defer_q       <= defer_d;
      rd_valid_q    <= rd_en;
    end
  end

  // Capture registers need no reset: they are only consumed in WRITE after a fresh capture.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    addr_q <= addr_d;
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    addr_d        = addr_q;
    load_count_d  = load_count_q;
    loaded_d      = loaded_q;
    update_d      = update_q;
    update_addr_d = update_addr_q;
    refill_ptr_d  = refill_ptr_q;
    overrun_d     = overrun_q;
    defer_d       = defer_q;
    ram_we        = 1'b0;
    complete      = 1'b0;
    clear_req     = 1'b0;
    timeout_fire  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (weight_data_done) begin
          data_d  = weight_data;
          addr_d  = write_weight_data_addr;
          state_d = StWrite;
        end
      end
      StWrite: begin
        ram_we  = 1'b1;
        state_d = StAck;
      end
      StAck: begin
        // A normal completion wins over the watchdog when both land in the same cycle.
        if (!weight_data_done) begin
          complete = 1'b1;
          state_d  = StIdle;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      load_count_d = load_count_q + 16'd1;
      loaded_d     = 1'b1;
    end

    clear_req = complete && update_q;
    if (clear_req) begin
      update_d     = 1'b0;
      refill_ptr_d = refill_ptr_q + 1'b1;
    end

    if (defer_q) begin
      defer_d       = 1'b0;
      update_d      = 1'b1;
      update_addr_d = {PARA_KERNEL{refill_ptr_q}};
    end

    if (consume) begin
      if (clear_req) begin
        defer_d = 1'b1;
      end else if (update_q || defer_q) begin
        overrun_d = 1'b1;
      end else if (loaded_q) begin
        update_d      = 1'b1;
        update_addr_d = {PARA_KERNEL{refill_ptr_q}};
      end
    end
  end

`ifdef WEIGHT_RX_TIMEOUT_EN
  logic [7:0] ack_cnt_q;
  logic       timeout_err_q;

  // ack_cnt_q counts ACK cycles already spent; the first ACK cycle sees 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_cnt_q <= (state_q == StAck) ? ack_cnt_q + 8'd1 : 8'd0;
      if (timeout_fire) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_hit = (state_q == StAck) && (ack_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, timeout_fire};
`endif

  // One RAM per kernel bank; reads are read-first against the same-cycle write.
  for (genvar b = 0; b < PARA_KERNEL; b++) begin : g_bank
    logic [KW-1:0] mem [DEPTH];
    logic [KW-1:0] rd_lane_q;

    always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
        mem[addr_q[b*ADDR_WIDTH +: ADDR_WIDTH]] <= data_q[b*KW +: KW];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_lane_q <= '0;
      end else if (rd_en) begin
        rd_lane_q <= mem[rd_addr];
      end
    end

    assign rd_data[b*KW +: KW] = rd_lane_q;
  end

  assign weight_ram_ready       = (state_q == StAck);
  assign update_weight_ram      = update_q;
  assign update_weight_ram_addr = update_addr_q;
  assign rd_valid               = rd_valid_q;
  assign load_count             = load_count_q;
  assign overrun                = overrun_q;

endmodule
